// File: rtl/addr_gen_pkg.sv
// Shared types and default widths for the multi-channel address generator.
// Macro ADDR_GEN_BOUND_CHECK_EN adds a per-channel upper address limit.
package addr_gen_pkg;

    localparam int unsigned ADDR_WIDTH     = 20;
    localparam int unsigned CNT_WIDTH      = 12;
    localparam int unsigned STRIDE_WIDTH   = 8;
    localparam int unsigned BYTE_SHIFT_DEF = 2;
    localparam int unsigned NUM_CH_DEF     = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]   base;
        logic [STRIDE_WIDTH-1:0] stride;
        logic [CNT_WIDTH-1:0]    len;
        logic                    rewind;
`ifdef ADDR_GEN_BOUND_CHECK_EN
        logic [ADDR_WIDTH-1:0]   limit;
`endif
    } ch_cfg_t;

endpackage

// File: rtl/multi_channel_addr_gen_if.sv
// Controller-facing bus of the address generator: config writes, per-channel
// control and per-channel status. Macro ADDR_GEN_BOUND_CHECK_EN adds limit signals.
interface multi_channel_addr_gen_if
    import addr_gen_pkg::*;
#(
    parameter int unsigned NUM_CH = NUM_CH_DEF
);
    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic                         cfg_we;
    logic [CH_W-1:0]              cfg_ch;
    logic [ADDR_WIDTH-1:0]        cfg_base;
    logic [STRIDE_WIDTH-1:0]      cfg_stride;
    logic [CNT_WIDTH-1:0]         cfg_len;
    logic                         cfg_rewind;
    logic [NUM_CH-1:0]            start;
    logic [NUM_CH-1:0]            adv;
    logic [NUM_CH-1:0]            abort;
    logic [NUM_CH*ADDR_WIDTH-1:0] addr;
    logic [NUM_CH-1:0]            busy;
    logic [NUM_CH-1:0]            burst_done;
`ifdef ADDR_GEN_BOUND_CHECK_EN
    logic [ADDR_WIDTH-1:0]        cfg_limit;
    logic [NUM_CH-1:0]            bound_err;
`endif

    modport master (
        output cfg_we, cfg_ch, cfg_base, cfg_stride, cfg_len, cfg_rewind,
        output start, adv, abort,
`ifdef ADDR_GEN_BOUND_CHECK_EN
        output cfg_limit,
        input  bound_err,
`endif
        input  addr, busy, burst_done
    );

    modport slave (
        input  cfg_we, cfg_ch, cfg_base, cfg_stride, cfg_len, cfg_rewind,
        input  start, adv, abort,
`ifdef ADDR_GEN_BOUND_CHECK_EN
        input  cfg_limit,
        output bound_err,
`endif
        output addr, busy, burst_done
    );

endinterface

// File: rtl/addr_gen_channel.sv
// One address-generator channel: IDLE/ACTIVE FSM, word address and beat counter.
// Macro ADDR_GEN_BOUND_CHECK_EN stops the channel when a beat would pass its limit.
module addr_gen_channel
    import addr_gen_pkg::*;
#(
    parameter int unsigned BYTE_SHIFT = BYTE_SHIFT_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  ch_cfg_t               cfg,
    input  logic                  start,
    input  logic                  adv,
    input  logic                  abort,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  busy,
`ifdef ADDR_GEN_BOUND_CHECK_EN
    output logic                  bound_err,
`endif
    output logic                  burst_done
);

    state_t                state_q, state_d;
    ch_cfg_t               run_q, run_d;
    logic [ADDR_WIDTH-1:0] word_q, word_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  done_d;
`ifdef ADDR_GEN_BOUND_CHECK_EN
    logic                  err_d;
    logic [ADDR_WIDTH:0]   sum_ext;
`endif

    // Next-state logic; priority abort > start > adv.
    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        word_d  = word_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
`ifdef ADDR_GEN_BOUND_CHECK_EN
        err_d   = 1'b0;
        sum_ext = {1'b0, word_q} + (ADDR_WIDTH+1)'(run_q.stride);
`endif
        if (abort) begin
            state_d = IDLE;
            word_d  = '0;
            cnt_d   = '0;
        end else if (start) begin
            state_d = ACTIVE;
            run_d   = cfg;
            word_d  = cfg.base;
            cnt_d   = cfg.len;
        end else begin
            case (state_q)
                ACTIVE: begin
                    if (adv) begin
`ifdef ADDR_GEN_BOUND_CHECK_EN
                        if (sum_ext > {1'b0, run_q.limit}) begin
                            err_d   = 1'b1;
                            state_d = IDLE;
                        end else
`endif
                        if (cnt_q == CNT_WIDTH'(1)) begin
                            done_d = 1'b1;
                            if (run_q.rewind) begin
                                word_d = run_q.base;
                                cnt_d  = run_q.len;
                            end else begin
                                state_d = IDLE;
                            end
                        end else begin
                            // len 0 loads zero and wraps to all ones: 2^CNT_WIDTH beats
                            word_d = word_q + ADDR_WIDTH'(run_q.stride);
                            cnt_d  = cnt_q - CNT_WIDTH'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // State and registered outputs; addr/busy track the same edge as the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            run_q      <= '0;
            word_q     <= '0;
            cnt_q      <= '0;
            addr       <= '0;
            busy       <= 1'b0;
            burst_done <= 1'b0;
`ifdef ADDR_GEN_BOUND_CHECK_EN
            bound_err  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            run_q      <= run_d;
            word_q     <= word_d;
            cnt_q      <= cnt_d;
            addr       <= word_d << BYTE_SHIFT;
            busy       <= (state_d == ACTIVE);
            burst_done <= done_d;
`ifdef ADDR_GEN_BOUND_CHECK_EN
            bound_err  <= err_d;
`endif
        end
    end

endmodule

// File: rtl/multi_channel_addr_gen.sv
// NUM_CH independent word-address streams with shadow config registers.
// Macro ADDR_GEN_BOUND_CHECK_EN adds per-channel limit registers and bound_err.
module multi_channel_addr_gen
    import addr_gen_pkg::*;
#(
    parameter int unsigned NUM_CH     = NUM_CH_DEF,
    parameter int unsigned BYTE_SHIFT = BYTE_SHIFT_DEF
) (
    input  logic                    core_clk,
    input  logic                    reset,
    multi_channel_addr_gen_if.slave bus
);

    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    ch_cfg_t                      cfg_q [NUM_CH];
    ch_cfg_t                      cfg_wr_c;
    logic [NUM_CH*ADDR_WIDTH-1:0] addr_all;

    always_comb begin
        cfg_wr_c        = '0;
        cfg_wr_c.base   = bus.cfg_base;
        cfg_wr_c.stride = bus.cfg_stride;
        cfg_wr_c.len    = bus.cfg_len;
        cfg_wr_c.rewind = bus.cfg_rewind;
`ifdef ADDR_GEN_BOUND_CHECK_EN
        cfg_wr_c.limit  = bus.cfg_limit;
`endif
    end

    // Config decode; a cfg_ch with no matching channel writes nothing.
    always_ff @(posedge core_clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (reset) begin
                cfg_q[i] <= '0;
`ifdef ADDR_GEN_BOUND_CHECK_EN
                cfg_q[i].limit <= '1;
`endif
            end else if (bus.cfg_we && (bus.cfg_ch == CH_W'(i))) begin
                cfg_q[i] <= cfg_wr_c;
            end
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        addr_gen_channel #(
            .BYTE_SHIFT (BYTE_SHIFT)
        ) u_ch (
            .clk        (core_clk),
            .reset      (reset),
            .cfg        (cfg_q[i]),
            .start      (bus.start[i]),
            .adv        (bus.adv[i]),
            .abort      (bus.abort[i]),
            .addr       (addr_all[i*ADDR_WIDTH +: ADDR_WIDTH]),
            .busy       (bus.busy[i]),
`ifdef ADDR_GEN_BOUND_CHECK_EN
            .bound_err  (bus.bound_err[i]),
`endif
            .burst_done (bus.burst_done[i])
        );
    end

    assign bus.addr = addr_all;

endmodule

// File: doc/multi_channel_addr_gen.md
Name: multi_channel_addr_gen

Overview:
Parametrised successor to the single-channel interface-unit address generator. Provides NUM_CH independent word-address streams, each with its own programmable base, stride, burst length and end-of-burst mode (rewind-and-loop or stop-and-hold). Sits in the interface unit between the transfer controller and the off-chip/GLB memory port; each channel feeds one data stream (ifmap, filter, psum read, psum write).

Parameters:
ADDR_WIDTH, 20, width of word address and of output byte address
NUM_CH, 4, number of independent channels (1..8)
CNT_WIDTH, 12, width of burst-length / beat counter
STRIDE_WIDTH, 8, width of per-channel word stride (unsigned)
BYTE_SHIFT, 2, left shift from word to byte address

Ports:
core_clk  in  1  single clock, all state updates on rising edge
reset  in  1  synchronous, active-high
cfg_we  in  1  config write strobe
cfg_ch  in  $clog2(NUM_CH)  channel targeted by config write
cfg_base  in  ADDR_WIDTH  word base address
cfg_stride  in  STRIDE_WIDTH  word increment per beat
cfg_len  in  CNT_WIDTH  beats per burst; 0 encodes 2^CNT_WIDTH
cfg_rewind  in  1  1 = reload base and loop at burst end; 0 = stop and hold
start  in  NUM_CH  per-channel burst start
adv  in  NUM_CH  per-channel advance (one beat consumed)
abort  in  NUM_CH  per-channel abort
addr  out  NUM_CH*ADDR_WIDTH  per-channel byte address, channel i at [i*ADDR_WIDTH +: ADDR_WIDTH]
busy  out  NUM_CH  channel in ACTIVE
burst_done  out  NUM_CH  one-cycle pulse on last beat of a burst

Behaviour:
- Reset: all channels IDLE; addr, busy, burst_done, all config and working registers = 0.
- Config registers per channel (base, stride, len, rewind) written on cfg_we; effective at the next start only. A running burst uses copies latched at start.
- Channel FSM, states IDLE and ACTIVE:
  - IDLE + start: latch config; word_addr <= base; beat_cnt <= len; -> ACTIVE. adv in the same cycle is ignored.
  - ACTIVE + adv, beat_cnt != 1: word_addr += stride; beat_cnt -= 1.
  - ACTIVE + adv, beat_cnt == 1: burst_done pulses next cycle. If rewind=1: word_addr <= base, beat_cnt <= len, stay ACTIVE. If rewind=0: word_addr unchanged (holds last beat address), -> IDLE.
  - ACTIVE + start (no abort): restart, identical to IDLE + start.
  - abort (any state): -> IDLE, word_addr <= 0, beat_cnt <= 0, no burst_done. Priority: reset > abort > start > adv.
- Outputs registered: addr = word_addr << BYTE_SHIFT truncated to ADDR_WIDTH; reflects state one cycle after the triggering edge. No combinational path from any input to any output.
- Arithmetic: word_addr addition is modulo 2^ADDR_WIDTH (silent wrap); stride zero-extended.
- busy = (state == ACTIVE). Channels are fully independent; simultaneous events on different channels never interact.
- cfg_ch >= NUM_CH: write ignored.

Optional Feature:
Macro ADDR_GEN_BOUND_CHECK_EN. With it: extra ports cfg_limit (in, ADDR_WIDTH) and bound_err (out, NUM_CH); per-channel limit register written with the other config (reset = all ones). On adv, if word_addr + stride > limit (unwrapped, ADDR_WIDTH+1-bit compare): word_addr and beat_cnt hold, bound_err pulses one cycle, channel -> IDLE. Without it: no limit ports or logic; wrap-around as above.

Decomposition:
- Package addr_gen_pkg: state enum (IDLE, ACTIVE), channel config struct (base, stride, len, rewind[, limit]), default widths as localparams.
- One sub-module: addr_gen_channel (single-channel FSM + counters), instantiated NUM_CH times by generate; top holds config decode and output packing.

Test Plan:
- Reset mid-burst: ch0 ACTIVE at word 0x10, assert reset one cycle -> next cycle addr[0]=0, busy=0, config reads back zero (start gives base 0).
- Stop mode: ch1 base 0x100, stride 4, len 3, rewind 0; start, then adv x3 -> byte addr 0x400, 0x410, 0x420, holds 0x420; burst_done[1] pulses once; busy drops.
- Rewind mode: ch2 base 0x20, stride 1, len 2, rewind 1; 5 adv -> word 0x20,0x21,0x20,0x21,0x20,0x21; burst_done pulses after beats 2 and 4; busy stays 1.
- Wrap and priority: base 0xFFFFE, stride 3, len 4; adv -> word 0x00001; then start+adv+abort same cycle -> IDLE, addr 0, no burst_done.
- Independence: ch0 and ch3 started same cycle with different configs, interleaved adv -> each sequence matches its own model; cfg write to ch3 mid-burst does not change ch3 sequence until next start.
- Bound check (macro on): limit 0x105, base 0x100, stride 4 -> first adv to 0x104 ok; second adv -> bound_err pulse, word holds 0x104, busy=0.
